bus_dma_master: RTL and testbench

Single-channel block-copy bus master that sits directly upstream of the bus arbiter. On a `start` pulse it raises `m_req`, waits for `m_grant`, and copies `len` consecutive words from `src_addr` to `dst_addr`, one read then one write per word. It releases the bus and pulses `done` when the copy finishes. It lets a compute core move operand and result blocks to and from shared RAM without CPU involvement.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_dma_master_if.sv | 22 ++
 rtl/bus_dma_master.sv | 144 ++++++++++++++
 tb/tb_bus_dma_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths for the arbiter, bus mux and DMA master,
// plus the DMA master state encoding.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned DMA_LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } dma_state_t;

endpackage

// File: rtl/bus_dma_master_if.sv
// Master-side bus port: request/grant handshake plus the shared address/data bus.
interface bus_dma_master_if #(
    parameter int unsigned ADDR_W = bus_pkg::BUS_ADDR_W,
    parameter int unsigned DATA_W = bus_pkg::BUS_DATA_W
);
    logic              m_req;
    logic              m_grant;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_dout,
        output m_grant, m_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// Single-channel block-copy bus master: reads len words from src and writes them to dst,
// one read then one write per word, holding the bus request for the whole copy.
module bus_dma_master
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned DATA_W = BUS_DATA_W,
    parameter int unsigned LEN_W  = DMA_LEN_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_src_addr,
    input  logic [ADDR_W-1:0]  i_dst_addr,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_busy,
    output logic               o_done,
    bus_dma_master_if.master   bus
);

    dma_state_t        r_state;
    dma_state_t        w_state_next;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  w_idx_next;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              w_accept;
    logic              w_last;

    logic              r_req,  w_req;
    logic              r_wr,   w_wr;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_dout, w_dout;
    logic              r_busy, w_busy;
    logic              r_done, w_done;

    assign w_accept = (r_state == ST_IDLE) && i_start && (i_len != '0);
    assign w_last   = (LEN_W'(r_idx + LEN_W'(1)) == r_len);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and word index; a lost grant drops back to REQ with idx unchanged
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_len != '0) ? ST_REQ : ST_DONE;
                    w_idx_next   = '0;
                end
            end
            ST_REQ:  if (bus.m_grant) w_state_next = ST_RD;
            ST_RD:   w_state_next = bus.m_grant ? ST_CAP : ST_REQ;
            ST_CAP:  w_state_next = bus.m_grant ? ST_WR : ST_REQ;
            ST_WR: begin
                if (!bus.m_grant) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_idx_next   = LEN_W'(r_idx + LEN_W'(1));
                    w_state_next = w_last ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with the state
    always_comb begin
        w_req  = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        w_dout = '0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (w_state_next)
            ST_REQ: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
            end
            ST_RD, ST_CAP: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
                w_addr = ADDR_W'(r_src + ADDR_W'(w_idx_next));
            end
            ST_WR: begin
                // WR is only entered from CAP, so m_din here is the word read for this idx
                w_req  = 1'b1;
                w_busy = 1'b1;
                w_wr   = 1'b1;
                w_addr = ADDR_W'(r_dst + ADDR_W'(w_idx_next));
                w_dout = bus.m_din;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    // Argument latch, index counter and output registers (r_dout doubles as the data buffer)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_src  <= '0;
            r_dst  <= '0;
            r_req  <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len <= i_len;
                r_src <= i_src_addr;
                r_dst <= i_dst_addr;
            end
            r_idx  <= w_idx_next;
            r_req  <= w_req;
            r_wr   <= w_wr;
            r_addr <= w_addr;
            r_dout <= w_dout;
            r_busy <= w_busy;
            r_done <= w_done;
        end
    end

    assign bus.m_req  = r_req;
    assign bus.m_wr   = r_wr;
    assign bus.m_addr = r_addr;
    assign bus.m_dout = r_dout;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master with a two-stage registered arbiter model and a word RAM.
module tb_bus_dma_master;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;

    bus_dma_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_dma_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (start),
        .i_src_addr (src),
        .i_dst_addr (dst),
        .i_len      (len),
        .o_busy     (busy),
        .o_done     (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Arbiter: registered state then registered grant; force_low models a grant drop
    logic arb_st, arb_grant;
    logic force_low = 1'b0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_st    <= 1'b0;
            arb_grant <= 1'b0;
        end else begin
            arb_st    <= bus.m_req;
            arb_grant <= arb_st;
        end
    end
    assign bus.m_grant = arb_grant & ~force_low;

    // RAM: read data valid the cycle after the address; preload port used while idle
    logic [DW-1:0] mem [0:65535];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        bus.m_din <= mem[bus.m_addr];
        if (pl_en)          mem[pl_addr]  <= pl_data;
        else if (bus.m_wr)  mem[bus.m_addr] <= bus.m_dout;
    end

    int            done_cnt = 0;
    int            req_cnt  = 0;
    logic [AW-1:0] wlog [$];
    always @(posedge clk) begin
        if (reset_n) begin
            if (done)       done_cnt++;
            if (bus.m_req)  req_cnt++;
            if (bus.m_wr)   wlog.push_back(bus.m_addr);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    // Pulse start for one edge (edge k); returns one tick after edge k
    task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req"},  32'(bus.m_req),  32'h0);
        check({tag, ".wr"},   32'(bus.m_wr),   32'h0);
        check({tag, ".addr"}, 32'(bus.m_addr), 32'h0);
        check({tag, ".dout"}, bus.m_dout,      32'h0);
        check({tag, ".busy"}, 32'(busy),       32'h0);
        check({tag, ".done"}, 32'(done),       32'h0);
    endtask

    initial begin
        int n;
        int d0;
        int w0;
        int r0;

        // Reset
        step();
        step();
        check_idle_outputs("rst_hold");
        reset_n = 1'b1;
        step();
        check_idle_outputs("rst_idle");

        preload(16'h0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) preload(AW'(16'h0020 + i), 32'h1111_0000 + 32'(i));
        gap();

        // Single word with exact cycle timing
        start_xfer(16'h0010, 16'h0080, 8'd1);
        check("t1.req_k",  32'(bus.m_req), 32'h1);
        check("t1.busy_k", 32'(busy),      32'h1);
        step();
        step();
        check("t1.req_wait_addr", 32'(bus.m_addr), 32'h0);
        step();
        check("t1.rd_addr", 32'(bus.m_addr), 32'h0010);
        check("t1.rd_wr",   32'(bus.m_wr),   32'h0);
        step();
        check("t1.cap_addr", 32'(bus.m_addr), 32'h0010);
        step();
        check("t1.wr_addr", 32'(bus.m_addr), 32'h0080);
        check("t1.wr_wr",   32'(bus.m_wr),   32'h1);
        check("t1.wr_dout", bus.m_dout,      32'hDEAD_BEEF);
        step();
        check("t1.done", 32'(done),       32'h1);
        check("t1.busy", 32'(busy),       32'h0);
        check("t1.req",  32'(bus.m_req),  32'h0);
        check("t1.addr", 32'(bus.m_addr), 32'h0);
        step();
        check("t1.done_pulse", 32'(done), 32'h0);
        check("t1.mem80", mem[16'h0080], 32'hDEAD_BEEF);
        gap();

        // Four words, ascending order and done latency 3+3N
        d0 = done_cnt;
        w0 = wlog.size();
        start_xfer(16'h0020, 16'h0040, 8'd4);
        run_done(n);
        check("t2.latency", 32'(n), 32'd15);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2.mem",   mem[AW'(16'h0040 + i)], 32'h1111_0000 + 32'(i));
            check("t2.order", 32'(wlog[w0 + i]),      32'h0040 + 32'(i));
        end
        check("t2.ndone", 32'(done_cnt - d0), 32'd1);
        gap();

        // Zero length: immediate done, no bus activity
        r0 = req_cnt;
        w0 = wlog.size();
        start_xfer(16'h0020, 16'h00C0, 8'd0);
        check("t3.done", 32'(done),      32'h1);
        check("t3.req",  32'(bus.m_req), 32'h0);
        check("t3.busy", 32'(busy),      32'h0);
        step();
        check("t3.done_pulse", 32'(done), 32'h0);
        gap();
        check("t3.req_cycles", 32'(req_cnt - r0),     32'd0);
        check("t3.writes",     32'(wlog.size() - w0), 32'd0);

        // start while busy is ignored
        preload(16'h0030, 32'hAAAA_0001);
        preload(16'h0031, 32'hAAAA_0002);
        for (int i = 0; i < 3; i++) preload(AW'(16'h0060 + i), 32'h0);
        gap();
        d0 = done_cnt;
        w0 = wlog.size();
        start_xfer(16'h0030, 16'h0050, 8'd2);
        for (int i = 0; i < 4; i++) step();
        start_xfer(16'h0020, 16'h0060, 8'd3);
        run_done(n);
        check("t4.latency", 32'(n + 5), 32'd9);
        step();
        check("t4.mem50", mem[16'h0050], 32'hAAAA_0001);
        check("t4.mem51", mem[16'h0051], 32'hAAAA_0002);
        check("t4.mem60", mem[16'h0060], 32'h0);
        check("t4.ndone",  32'(done_cnt - d0),    32'd1);
        check("t4.writes", 32'(wlog.size() - w0), 32'd2);
        gap();
        check("t4.idle_after", 32'(busy), 32'h0);

        // Grant dropped for 3 cycles during CAP of word 2
        for (int i = 0; i < 3; i++) preload(AW'(16'h0070 + i), 32'h0);
        gap();
        d0 = done_cnt;
        w0 = wlog.size();
        start_xfer(16'h0020, 16'h0070, 8'd3);
        for (int i = 0; i < 7; i++) step();
        check("t5.cap_addr", 32'(bus.m_addr), 32'h0021);
        force_low = 1'b1;
        step();
        check("t5.req_held", 32'(bus.m_req),  32'h1);
        check("t5.released", 32'(bus.m_addr), 32'h0);
        check("t5.busy",     32'(busy),       32'h1);
        step();
        step();
        force_low = 1'b0;
        run_done(n);
        check("t5.latency", 32'(n + 10), 32'd17);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t5.mem",   mem[AW'(16'h0070 + i)], 32'h1111_0000 + 32'(i));
            check("t5.order", 32'(wlog[w0 + i]),      32'h0070 + 32'(i));
        end
        check("t5.ndone",  32'(done_cnt - d0),    32'd1);
        check("t5.writes", 32'(wlog.size() - w0), 32'd3);
        gap();

        // Source address wraps through 0xFFFF
        preload(16'hFFFE, 32'hCAFE_0000);
        preload(16'hFFFF, 32'hCAFE_0001);
        preload(16'h0000, 32'hCAFE_0002);
        preload(16'h0001, 32'hCAFE_0003);
        gap();
        start_xfer(16'hFFFE, 16'h0090, 8'd4);
        run_done(n);
        check("t6.latency", 32'(n), 32'd15);
        step();
        for (int i = 0; i < 4; i++)
            check("t6.mem", mem[AW'(16'h0090 + i)], 32'hCAFE_0000 + 32'(i));
        gap();

        // Reset asserted mid-WR discards the transfer
        preload(16'h00A0, 32'h0);
        gap();
        d0 = done_cnt;
        w0 = wlog.size();
        start_xfer(16'h0020, 16'h00A0, 8'd2);
        for (int i = 0; i < 5; i++) step();
        check("t7.in_wr", 32'(bus.m_wr), 32'h1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t7.async");
        step();
        reset_n = 1'b1;
        gap();
        check("t7.ndone",  32'(done_cnt - d0),    32'd0);
        check("t7.writes", 32'(wlog.size() - w0), 32'd0);
        check("t7.memA0",  mem[16'h00A0],         32'h0);
        start_xfer(16'h0010, 16'h00B0, 8'd1);
        run_done(n);
        check("t7.restart_latency", 32'(n), 32'd6);
        step();
        check("t7.memB0", mem[16'h00B0], 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
